// File: rtl/ym_seq_pkg.sv
// Shared types and algorithm routing tables for the FM slot sequencer.
// Routing tables are indexed by the 3-bit algorithm number.
package ym_seq_pkg;

  typedef enum logic [1:0] {
    OP4 = 2'd0,
    OP1 = 2'd1,
    OP3 = 2'd2,
    OP2 = 2'd3
  } op_grp_t;

  typedef logic [2:0] alg_t;

  // Bit n set means the control is active for algorithm n
  localparam logic [7:0] OP2_AT_OP4  = 8'h07;
  localparam logic [7:0] OP2_AT_OP3  = 8'h08;
  localparam logic [7:0] CUR1_AT_OP3 = 8'h04;
  localparam logic [7:0] CUR2_AT_OP1 = 8'h79;
  localparam logic [7:0] CUR2_AT_OP3 = 8'h1B;
  localparam logic [7:0] OP10_AT_OP4 = 8'h22;
  localparam logic [7:0] OP10_AT_OP3 = 8'h24;
  localparam logic [7:0] OUT_AT_OP1  = 8'h80;
  localparam logic [7:0] OUT_AT_OP3  = 8'hE0;
  localparam logic [7:0] OUT_AT_OP2  = 8'hF0;

endpackage

// File: rtl/ym_slot_cnt.sv
// Channel / operator-group slot counter with carry, resync and
// asynchronous reset; also tracks the flat slot index.
module ym_slot_cnt #(
  parameter int N_CH = 6,
  parameter int SW   = 5
) (
  input  logic          mclk_i,
  input  logic          rst_ni,
  input  logic          slot_en_i,
  input  logic          sync_i,
  output logic [SW-1:0] slot_o,
  output logic [2:0]    ch_o,
  output logic [1:0]    grp_o
);

  localparam logic [2:0]    CH_MAX   = 3'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(4 * N_CH - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    ch_q, ch_d;
  logic [1:0]    grp_q, grp_d;

  always_ff @(posedge mclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q <= '0;
      ch_q   <= '0;
      grp_q  <= '0;
    end else begin
      slot_q <= slot_d;
      ch_q   <= ch_d;
      grp_q  <= grp_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    ch_d   = ch_q;
    grp_d  = grp_q;
    if (sync_i) begin
      slot_d = '0;
      ch_d   = '0;
      grp_d  = '0;
    end else if (slot_en_i) begin
      if (ch_q == CH_MAX) begin
        ch_d  = '0;
        grp_d = grp_q + 2'd1;
      end else begin
        ch_d = ch_q + 3'd1;
      end
      slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
    end
  end

  assign slot_o = slot_q;
  assign ch_o   = ch_q;
  assign grp_o  = grp_q;

endmodule

// File: rtl/ym_slot_seq.sv
// FM operator-slot sequencer: slot/channel/group selects, timer edge,
// feedback select and routing decode. YM_SEQ_DAC_EN adds DAC strobes.
module ym_slot_seq
  import ym_seq_pkg::*;
#(
  parameter int N_CH       = 6,
  parameter int CH3_IDX    = 2,
  parameter int TIMER_SLOT = 2,
`ifdef YM_SEQ_DAC_EN
  parameter int DAC_PERIOD = 4,
  parameter int DAC_LAST   = 4,
`endif
  localparam int N_SLOT = 4 * N_CH,
  localparam int SW     = $clog2(N_SLOT)
) (
  input  logic          MCLK,
  input  logic          reset_n,
  input  logic          slot_en,
  input  logic          sync,
  input  logic [2:0]    connect,
  output logic [SW-1:0] slot,
  output logic [2:0]    ch,
  output logic [1:0]    op_grp,
  output logic          sel0,
  output logic          sel_last,
  output logic          ch3_sel,
  output logic          timer_ed,
  output logic          alg_fb_sel,
  output logic          alg_op2,
  output logic          alg_cur1,
  output logic          alg_cur2,
  output logic          alg_op1_0,
  output logic          alg_out
`ifdef YM_SEQ_DAC_EN
  ,
  output logic          dac_load,
  output logic          dac_out_sel,
  output logic          dac_last_ch
`endif
);

  localparam logic [SW-1:0] T_SLOT = SW'(TIMER_SLOT);
  localparam logic [SW-1:0] L_SLOT = SW'(N_SLOT - 1);

  logic [SW-1:0] slot_w;
  logic [2:0]    ch_w;
  logic [1:0]    grp_w;
  op_grp_t       grp;
  alg_t          a;

  logic [SW-1:0] prev_q;
  logic          fb_q, fb_d;

  ym_slot_cnt #(
    .N_CH (N_CH),
    .SW   (SW)
  ) u_cnt (
    .mclk_i    (MCLK),
    .rst_ni    (reset_n),
    .slot_en_i (slot_en),
    .sync_i    (sync),
    .slot_o    (slot_w),
    .ch_o      (ch_w),
    .grp_o     (grp_w)
  );

  assign grp = op_grp_t'(grp_w);
  assign a   = connect;

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      fb_q   <= 1'b0;
    end else begin
      prev_q <= slot_w;
      fb_q   <= fb_d;
    end
  end

  always_comb begin
    fb_d = fb_q;
    if (slot_en) fb_d = (grp == OP2);
  end

  assign slot       = slot_w;
  assign ch         = ch_w;
  assign op_grp     = grp_w;
  assign sel0       = (slot_w == '0);
  assign sel_last   = (slot_w == L_SLOT);
  assign ch3_sel    = (ch_w == 3'(CH3_IDX));
  // Pulse only while the slot differs from the one seen last MCLK
  assign timer_ed   = (slot_w == T_SLOT) && (prev_q != T_SLOT);
  assign alg_fb_sel = ~fb_q;

  always_comb begin
    alg_op2   = 1'b0;
    alg_cur1  = 1'b0;
    alg_cur2  = 1'b0;
    alg_op1_0 = 1'b0;
    alg_out   = 1'b0;
    unique case (1'b1)
      grp == OP4: begin
        alg_op2   = OP2_AT_OP4[a];
        alg_op1_0 = OP10_AT_OP4[a];
        alg_out   = 1'b1;
      end
      grp == OP1: begin
        alg_cur2 = CUR2_AT_OP1[a];
        alg_out  = OUT_AT_OP1[a];
      end
      grp == OP3: begin
        alg_op2   = OP2_AT_OP3[a];
        alg_cur1  = CUR1_AT_OP3[a];
        alg_cur2  = CUR2_AT_OP3[a];
        alg_op1_0 = OP10_AT_OP3[a];
        alg_out   = OUT_AT_OP3[a];
      end
      grp == OP2: begin
        alg_op1_0 = 1'b1;
        alg_out   = OUT_AT_OP2[a];
      end
      default: ;
    endcase
  end

`ifdef YM_SEQ_DAC_EN
  logic [31:0] slot_n;
  assign slot_n      = 32'(slot_w);
  assign dac_load    = (slot_n % DAC_PERIOD) == 32'd0;
  assign dac_out_sel = slot_n >= 32'(N_SLOT / 2);
  assign dac_last_ch = (slot_n >= 32'(DAC_LAST))
                    && (slot_n < 32'(DAC_LAST + 4));
`endif

endmodule

// File: tb/tb_ym_slot_seq.sv
// Bench for ym_slot_seq: N_CH=6 and N_CH=8 instances against a
// slot-level model, plus directed literal checks.
module tb_ym_slot_seq;

  logic       MCLK = 1'b0;
  logic       reset_n;
  logic       slot_en;
  logic       sync;
  logic [2:0] connect;
  logic       chk_en = 1'b0;

  int tests  = 0;
  int failed = 0;

  always #5 MCLK = ~MCLK;

  logic [4:0] a_slot, b_slot;
  logic [2:0] a_ch, b_ch;
  logic [1:0] a_grp, b_grp;
  logic a_sel0, a_sl, a_c3, a_tim, a_fb, a_op2, a_cu1, a_cu2, a_o10, a_out;
  logic b_sel0, b_sl, b_c3, b_tim, b_fb, b_op2, b_cu1, b_cu2, b_o10, b_out;
`ifdef YM_SEQ_DAC_EN
  logic a_dl, a_ds, a_dc, b_dl, b_ds, b_dc;
`endif

  ym_slot_seq #(
    .N_CH(6), .CH3_IDX(2), .TIMER_SLOT(2)
`ifdef YM_SEQ_DAC_EN
    , .DAC_PERIOD(4), .DAC_LAST(4)
`endif
  ) u_a (
    .MCLK(MCLK), .reset_n(reset_n), .slot_en(slot_en), .sync(sync),
    .connect(connect), .slot(a_slot), .ch(a_ch), .op_grp(a_grp),
    .sel0(a_sel0), .sel_last(a_sl), .ch3_sel(a_c3), .timer_ed(a_tim),
    .alg_fb_sel(a_fb), .alg_op2(a_op2), .alg_cur1(a_cu1),
    .alg_cur2(a_cu2), .alg_op1_0(a_o10), .alg_out(a_out)
`ifdef YM_SEQ_DAC_EN
    , .dac_load(a_dl), .dac_out_sel(a_ds), .dac_last_ch(a_dc)
`endif
  );

  ym_slot_seq #(
    .N_CH(8), .CH3_IDX(2), .TIMER_SLOT(2)
`ifdef YM_SEQ_DAC_EN
    , .DAC_PERIOD(4), .DAC_LAST(4)
`endif
  ) u_b (
    .MCLK(MCLK), .reset_n(reset_n), .slot_en(slot_en), .sync(sync),
    .connect(connect), .slot(b_slot), .ch(b_ch), .op_grp(b_grp),
    .sel0(b_sel0), .sel_last(b_sl), .ch3_sel(b_c3), .timer_ed(b_tim),
    .alg_fb_sel(b_fb), .alg_op2(b_op2), .alg_cur1(b_cu1),
    .alg_cur2(b_cu2), .alg_op1_0(b_o10), .alg_out(b_out)
`ifdef YM_SEQ_DAC_EN
    , .dac_load(b_dl), .dac_out_sel(b_ds), .dac_last_ch(b_dc)
`endif
  );

  // Model: one flat slot number per instance, plus timer and feedback state
  int NN[2] = '{6, 8};
  int m_slot[2];
  int m_tim[2];
  int m_fb[2];

  function automatic int nxt(int s, int n, logic sy, logic en);
    if (sy) return 0;
    if (en) return (s + 1) % (4 * n);
    return s;
  endfunction

  always @(posedge MCLK or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_slot[d] <= 0;
        m_tim[d]  <= 0;
        m_fb[d]   <= 0;
      end else begin
        m_slot[d] <= nxt(m_slot[d], NN[d], sync, slot_en);
        m_tim[d]  <= (nxt(m_slot[d], NN[d], sync, slot_en) == 2
                      && m_slot[d] != 2) ? 1 : 0;
        if (slot_en) m_fb[d] <= (m_slot[d] / NN[d] == 3) ? 1 : 0;
      end
    end
  end

  function automatic logic [31:0] expv(int s, int n, int tim, int fb,
                                       int a);
    logic [31:0] v;
    int g, c;
    g = s / n;
    c = s % n;
    v = '0;
    v[22:15] = 8'(s);
    v[14:12] = 3'(c);
    v[11:10] = 2'(g);
    v[9] = (s == 0);
    v[8] = (s == 4 * n - 1);
    v[7] = (c == 2);
    v[6] = (tim != 0);
    v[5] = (fb == 0);
    v[4] = (g == 0 && a <= 2) || (g == 2 && a == 3);
    v[3] = (g == 2 && a == 2);
    v[2] = (g == 1 && a inside {0, 3, 4, 5, 6})
        || (g == 2 && a inside {0, 1, 3, 4});
    v[1] = (g == 0 && a inside {1, 5}) || (g == 2 && a inside {2, 5})
        || (g == 3);
    v[0] = (g == 1 && a == 7) || (g == 2 && a >= 5)
        || (g == 3 && a >= 4) || (g == 0);
    return v;
  endfunction

  always @(posedge MCLK) begin
    logic [31:0] act, exp;
    #1;
    if (chk_en) begin
      act = {12'b0, a_slot, a_ch, a_grp, a_sel0, a_sl, a_c3, a_tim,
             a_fb, a_op2, a_cu1, a_cu2, a_o10, a_out};
      exp = expv(m_slot[0], 6, m_tim[0], m_fb[0], int'(connect));
      tests++;
      if (act !== exp) begin
        failed++;
        $display("FAIL model dut6 t=%0t act=%h exp=%h", $time, act, exp);
      end
      act = {12'b0, b_slot, b_ch, b_grp, b_sel0, b_sl, b_c3, b_tim,
             b_fb, b_op2, b_cu1, b_cu2, b_o10, b_out};
      exp = expv(m_slot[1], 8, m_tim[1], m_fb[1], int'(connect));
      tests++;
      if (act !== exp) begin
        failed++;
        $display("FAIL model dut8 t=%0t act=%h exp=%h", $time, act, exp);
      end
`ifdef YM_SEQ_DAC_EN
      tests++;
      if ({a_dl, a_ds, a_dc} !== {m_slot[0] % 4 == 0, m_slot[0] >= 12,
          m_slot[0] >= 4 && m_slot[0] < 8}) begin
        failed++;
        $display("FAIL dac dut6 t=%0t act=%b", $time, {a_dl, a_ds, a_dc});
      end
      tests++;
      if ({b_dl, b_ds, b_dc} !== {m_slot[1] % 4 == 0, m_slot[1] >= 16,
          m_slot[1] >= 4 && m_slot[1] < 8}) begin
        failed++;
        $display("FAIL dac dut8 t=%0t act=%b", $time, {b_dl, b_ds, b_dc});
      end
`endif
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    slot_en = 1'b0;
    sync    = 1'b0;
    connect = 3'd0;
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_slot", 32'(a_slot), 0);
    chk("rst_sel0", 32'(a_sel0), 1);
    chk("rst_sel_last", 32'(a_sl), 0);
    chk("rst_fb", 32'(a_fb), 1);
    chk("rst_op2", 32'(a_op2), 1);
    chk("rst_out", 32'(a_out), 1);
    chk("rst_op1_0", 32'(a_o10), 0);
    chk("rst_timer", 32'(a_tim), 0);
    connect = 3'd5;
    #1;
    chk("rst_op1_0_c5", 32'(a_o10), 1);
    chk("rst_op2_c5", 32'(a_op2), 0);
    connect = 3'd0;

    reset_n = 1'b1;
    slot_en = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 2) chk("timer_at2", 32'(a_tim), 1);
      if (k == 2) chk("ch3_at2", 32'(a_c3), 1);
      if (k == 3) chk("timer_at3", 32'(a_tim), 0);
      if (k == 8) chk("ch3_at8", 32'(a_c3), 1);
      if (k == 9) chk("grp_at9", 32'(a_grp), 1);
      if (k == 18) chk("fb_at18", 32'(a_fb), 1);
      if (k == 19) chk("fb_at19", 32'(a_fb), 0);
      if (k == 23) chk("sel_last_23", 32'(a_sl), 1);
      if (k == 24) chk("wrap_slot", 32'(a_slot), 0);
      if (k == 24) chk("wrap_fb", 32'(a_fb), 0);
    end

    tick();
    tick();
    chk("gap_timer_on", 32'(a_tim), 1);
    slot_en = 1'b0;
    tick();
    chk("gap_timer_off", 32'(a_tim), 0);
    chk("gap_hold", 32'(a_slot), 2);
    tick();
    slot_en = 1'b1;
    repeat (11) tick();
    chk("pre_sync", 32'(a_slot), 13);
    sync = 1'b1;
    tick();
    chk("sync_slot", 32'(a_slot), 0);
    tick();
    chk("sync_hold", 32'(a_slot), 0);
    chk("sync_b", 32'(b_slot), 0);
    sync = 1'b0;

    for (int c = 0; c < 8; c++) begin
      connect = 3'(c);
      for (int k = 1; k <= 24; k++) begin
        tick();
        if (c == 7 && k == 14) chk("c7_op3_out", 32'(a_out), 1);
        if (c == 2 && k == 13) chk("c2_op3_cur1", 32'(a_cu1), 1);
        if (c == 3 && k == 7) chk("c3_op1_cur2", 32'(a_cu2), 1);
      end
    end
    connect = 3'd0;

    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 10) chk("b_ch3_10", 32'(b_c3), 1);
      if (k == 16) chk("b_slot16", 32'(b_slot), 16);
      if (k == 16) chk("b_grp16", 32'(b_grp), 2);
      if (k == 31) chk("b_sel_last", 32'(b_sl), 1);
`ifdef YM_SEQ_DAC_EN
      if (k == 16) chk("b_dac_out16", 32'(b_ds), 1);
      if (k == 4) chk("b_dac_last4", 32'(b_dc), 1);
      if (k == 8) chk("b_dac_last8", 32'(b_dc), 0);
`endif
    end

    repeat (9) tick();
    chk("pre_rst_slot", 32'(a_slot), 17);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_slot", 32'(a_slot), 0);
    chk("arst_ch", 32'(a_ch), 0);
    chk("arst_grp", 32'(a_grp), 0);
    chk("arst_sel0", 32'(a_sel0), 1);
    chk("arst_fb", 32'(a_fb), 1);
    chk("arst_out", 32'(a_out), 1);
    chk("arst_b_slot", 32'(b_slot), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("restart_slot", 32'(a_slot), 1);
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
